// File: rtl/adv_ddr.sv
// ADV75xx 12-bit DDR output formatter: resynchronises the pixel clock into clk_ddr,
// regenerates it and splits each 24-bit pixel into two half-words around its edges.
module adv_ddr #(
  parameter int SYNC_STAGES = 2,
  parameter bit LOW_FIRST   = 1'b1
) (
  input  logic        clk_ddr,
  input  logic        reset_n,
  input  logic        clk_pixel,
  input  logic        videoblank,
  input  logic        vsync,
  input  logic        hsync,
  input  logic [23:0] data,
  output logic        clk_pixel_out,
  output logic        de_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic [11:0] data_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   rise_s;
  logic [23:0]            hold_data_q, hold_data_d;
  logic                   hold_de_q, hold_de_d;
  logic                   hold_hs_q, hold_hs_d;
  logic                   hold_vs_q, hold_vs_d;
  logic [1:0]             phase_q, phase_d;
  logic [11:0]            first_s, second_s;
  logic                   clk_out_q, clk_out_d;
  logic                   de_q, de_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic [11:0]            dout_q, dout_d;

  // Next-state logic: sync chain, capture on the synchronised rise, phase and output selection
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], clk_pixel};
    edge_d      = sync_q[SYNC_STAGES-1];
    rise_s      = sync_q[SYNC_STAGES-1] & ~edge_q;
    hold_data_d = hold_data_q;
    hold_de_d   = hold_de_q;
    hold_hs_d   = hold_hs_q;
    hold_vs_d   = hold_vs_q;
    phase_d     = phase_q;
    if (rise_s) begin
      hold_data_d = data;
      hold_de_d   = ~videoblank;
      hold_hs_d   = hsync;
      hold_vs_d   = vsync;
      phase_d     = 2'd0;
    end else if (phase_q != 2'd3) begin
      phase_d = phase_q + 2'd1;
    end else begin
      phase_d = 2'd3;
    end

    first_s  = LOW_FIRST ? hold_data_q[11:0]  : hold_data_q[23:12];
    second_s = LOW_FIRST ? hold_data_q[23:12] : hold_data_q[11:0];
    // Output clock rises mid-way through the first half and falls mid-way through the second
    case (phase_q)
      2'd0: begin clk_out_d = 1'b0; dout_d = first_s;  end
      2'd1: begin clk_out_d = 1'b1; dout_d = first_s;  end
      2'd2: begin clk_out_d = 1'b1; dout_d = second_s; end
      default: begin clk_out_d = 1'b0; dout_d = second_s; end
    endcase

    de_d = de_q;
    hs_d = hs_q;
    vs_d = vs_q;
    if (phase_q == 2'd0) begin
      de_d = hold_de_q;
      hs_d = hold_hs_q;
      vs_d = hold_vs_q;
    end else begin
      de_d = de_q;
      hs_d = hs_q;
      vs_d = vs_q;
    end
  end

  // State and output registers; idle phase is 3 so a stopped input clock leaves the output low
  always_ff @(posedge clk_ddr or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      edge_q      <= 1'b0;
      hold_data_q <= 24'h000000;
      hold_de_q   <= 1'b0;
      hold_hs_q   <= 1'b0;
      hold_vs_q   <= 1'b0;
      phase_q     <= 2'd3;
      clk_out_q   <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      dout_q      <= 12'h000;
    end else begin
      sync_q      <= sync_d;
      edge_q      <= edge_d;
      hold_data_q <= hold_data_d;
      hold_de_q   <= hold_de_d;
      hold_hs_q   <= hold_hs_d;
      hold_vs_q   <= hold_vs_d;
      phase_q     <= phase_d;
      clk_out_q   <= clk_out_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      dout_q      <= dout_d;
    end
  end

  assign clk_pixel_out = clk_out_q;
  assign de_out        = de_q;
  assign hsync_out     = hs_q;
  assign vsync_out     = vs_q;
  assign data_out      = dout_q;

endmodule

// File: tb/tb_adv_ddr.sv
// Randomised bench for adv_ddr: both half-word orders checked every cycle against a
// pixel-level timeline model (pixel shown from rise+4 cycles, phase = cycles since then).
`timescale 1ns/100ps
module tb_adv_ddr;

  logic        clk_ddr = 1'b0;
  logic        reset_n;
  logic        clk_pixel, videoblank, vsync, hsync;
  logic [23:0] data;
  logic        cpo1, de1, vs1, hs1;
  logic [11:0] do1;
  logic        cpo0, de0, vs0, hs0;
  logic [11:0] do0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises[$];
  logic prev_cp;
  logic [23:0] rec_d  [0:4095];
  logic        rec_vb [0:4095];
  logic        rec_hs [0:4095];
  logic        rec_vs [0:4095];

  adv_ddr #(.SYNC_STAGES(2), .LOW_FIRST(1'b1)) dut_lf1 (
    .clk_ddr(clk_ddr), .reset_n(reset_n), .clk_pixel(clk_pixel), .videoblank(videoblank),
    .vsync(vsync), .hsync(hsync), .data(data), .clk_pixel_out(cpo1), .de_out(de1),
    .vsync_out(vs1), .hsync_out(hs1), .data_out(do1));

  adv_ddr #(.SYNC_STAGES(2), .LOW_FIRST(1'b0)) dut_lf0 (
    .clk_ddr(clk_ddr), .reset_n(reset_n), .clk_pixel(clk_pixel), .videoblank(videoblank),
    .vsync(vsync), .hsync(hsync), .data(data), .clk_pixel_out(cpo0), .de_out(de0),
    .vsync_out(vs0), .hsync_out(hs0), .data_out(do0));

  always #1 clk_ddr = ~clk_ddr;
  always @(posedge clk_ddr) cyc++;

  task automatic cmp1(input string tag, input int n, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  task automatic cmp12(input string tag, input int n, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // Reference: latest pixel whose output window has started, shown for phase min(n-start,3)
  task automatic check(input int n);
    int c;
    int ph;
    logic [23:0] d;
    logic e_clk, e_de, e_hs, e_vs;
    logic [11:0] e_d1, e_d0;
    c = -1;
    foreach (rises[i]) if (rises[i] + 4 <= n) c = rises[i];
    e_clk = 1'b0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
    e_d1 = 12'h000; e_d0 = 12'h000;
    if (reset_n === 1'b1 && c >= 0) begin
      ph = n - (c + 4);
      if (ph > 3) ph = 3;
      d = rec_d[c + 2];
      e_clk = (ph == 1 || ph == 2);
      e_d1  = (ph < 2) ? d[11:0]  : d[23:12];
      e_d0  = (ph < 2) ? d[23:12] : d[11:0];
      e_de  = ~rec_vb[c + 2];
      e_hs  = rec_hs[c + 2];
      e_vs  = rec_vs[c + 2];
    end
    cmp1 ("lf1_clk", n, cpo1, e_clk);
    cmp12("lf1_data", n, do1, e_d1);
    cmp1 ("lf1_de", n, de1, e_de);
    cmp1 ("lf1_hs", n, hs1, e_hs);
    cmp1 ("lf1_vs", n, vs1, e_vs);
    cmp1 ("lf0_clk", n, cpo0, e_clk);
    cmp12("lf0_data", n, do0, e_d0);
    cmp1 ("lf0_de", n, de0, e_de);
    cmp1 ("lf0_hs", n, hs0, e_hs);
    cmp1 ("lf0_vs", n, vs0, e_vs);
  endtask

  // One clk_ddr cycle: check the state after the last rising edge, then drive new inputs
  task automatic step(input logic rn, input logic cp, input logic [23:0] d);
    @(negedge clk_ddr);
    check(cyc);
    reset_n    = rn;
    clk_pixel  = cp;
    data       = d;
    videoblank = 1'($urandom_range(1, 0));
    hsync      = 1'($urandom_range(1, 0));
    vsync      = 1'($urandom_range(1, 0));
    rec_d[cyc]  = d;
    rec_vb[cyc] = videoblank;
    rec_hs[cyc] = hsync;
    rec_vs[cyc] = vsync;
    if (!rn) begin
      rises.delete();
      prev_cp = 1'b0;
      #0.5;
      check(cyc);
    end else begin
      if (cp && !prev_cp) rises.push_back(cyc);
      prev_cp = cp;
    end
  endtask

  task automatic pixel(input logic [23:0] d);
    for (int k = 0; k < 4; k++) step(1'b1, (k < 2), d);
  endtask

  initial begin
    reset_n = 1'b0; clk_pixel = 1'b0; videoblank = 1'b0; hsync = 1'b0; vsync = 1'b0;
    data = 24'h000000; prev_cp = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'($urandom_range(1, 0)), 24'($urandom));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 24'h000000);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 8; i++) pixel((i % 2 == 0) ? 24'hAADBFF : 24'h552400);
    pixel(24'h123456);
    pixel(24'h123456);
    for (int i = 0; i < 20; i++) pixel(24'($urandom));
    step(1'b1, 1'b0, 24'hAADBFF);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 24'hAADBFF);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 24'hAADBFF);
    for (int i = 0; i < 4; i++) pixel((i % 2 == 0) ? 24'h552400 : 24'hAADBFF);
    for (int i = 0; i < 6; i++) step(1'b1, (i < 2), 24'h5A5A5A);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 24'h5A5A5A);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h5A5A5A);
    for (int i = 0; i < 6; i++) pixel(24'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'h000000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
